stopwatch_core: RTL and testbench
=================================

# stopwatch_core

Time-keeping core of the stopwatch, downstream of the clock divider. Samples the divider's 100 Hz square wave in the 50 MHz domain, turns each rising edge into a one-cycle count enable, and runs a six-digit BCD counter (MM:SS.cc, 00:00.00–59:59.99). A start/stop/clear/lap state machine drives it, and it feeds the 7-segment display multiplexer.

## Interface
Parameters:
- MAX_MIN_TENS, 5: highest value of the minutes-tens digit before wrap. Legal range 1–9.

Ports:
- clk_50MHz  input  1  system clock; every register is clocked here.
- rst  input  1  synchronous, active-high reset.
- clk_100Hz  input  1  100 Hz square wave from the clock divider, synchronous to clk_50MHz.
- btn_start_stop  input  1  debounced one-cycle pulse; toggles run/stop.
- btn_clear  input  1  debounced one-cycle pulse; zeroes the count when not running.
- btn_lap  input  1  debounced one-cycle pulse; freezes or releases the display.
- bcd_time  output  24  display value {m1,m0,s1,s0,c1,c0}, 4-bit BCD each.
- running  output  1  high in RUN or LAP.
- lap_active  output  1  high in LAP.
- overflow  output  1  sticky; set on wrap from the maximum count.

## Operation
- Edge detect: clk_100Hz_d registers clk_100Hz. tick = clk_100Hz & ~clk_100Hz_d. clk_100Hz_d resets to 1, so a source that is already high at reset release produces no tick.
- Count enable: cnt_en = tick & (state == RUN | state == LAP). The enable is judged on the current state, before any transition at the same edge.
- Digit chain: c0 0–9, c1 0–9, s0 0–9, s1 0–5, m0 0–9, m1 0–MAX_MIN_TENS. Carry ripples combinationally within one cycle. No digit ever holds a non-BCD value.
- Wrap: on cnt_en at MAX_MIN_TENS 9:59.99, all digits go to 0 and overflow is set. overflow stays set until clear or rst.
- FSM states: IDLE, RUN, STOP, LAP.
  - IDLE: start_stop goes to RUN. Others are ignored.
  - RUN: start_stop goes to STOP. lap goes to LAP and captures lap_reg. clear is ignored.
  - LAP: start_stop goes to STOP. lap goes to RUN. clear is ignored.
  - STOP: start_stop goes to RUN. clear goes to IDLE, zeroes counters and clears overflow. lap is ignored.
- Simultaneous buttons: priority is clear > start_stop > lap, applied after the ignore rules above. Example: clear+start_stop in RUN acts as start_stop.
- Tick together with start_stop:
  - RUN to STOP: the tick is counted.
  - STOP/IDLE to RUN: the tick is not counted.
- Lap capture: lap_reg takes the pre-edge counter value. An increment at the same edge does not appear in lap_reg.
- Display mux: bcd_time = lap_reg in LAP, otherwise the live counter. The mux is purely combinational from registers.

## Timing
- Reset values: state IDLE, all digits 0, lap_reg 0, clk_100Hz_d 1. Outputs: bcd_time 24'h000000, running 0, lap_active 0, overflow 0.
- rst has priority over every input at the same edge. rst mid-count returns all of the above in one cycle.
- Latency: a rising edge of clk_100Hz sampled at edge N, while running, makes bcd_time show the incremented value after edge N.
- Button latency: a pulse sampled at edge N changes state, running, lap_active and bcd_time source after edge N.
- Increment rate: exactly one per clk_100Hz period. Buttons wider than one cycle act again on each cycle; upstream guarantees single-cycle pulses.

## Configuration
- STOPWATCH_LAP_EN defined:
  - LAP state, lap_reg and the display mux are present, as described above.
- STOPWATCH_LAP_EN undefined:
  - LAP state and lap_reg are removed.
  - btn_lap is ignored and lap_active is tied to 0.
  - bcd_time is always the live counter. Every other behaviour is identical.

## Structure
- Package stopwatch_pkg holds:
  - state enum sw_state_t (IDLE, RUN, STOP, LAP);
  - BCD_W = 4, NUM_DIGITS = 6;
  - the digit-limit constants 9 and 5.
- Sub-module bcd_digit: one modulo-N BCD digit with count enable, synchronous clear, and combinational carry-out (en & digit == N-1). It is instantiated six times.

## Test plan
- Reset then start: rst for 2 cycles, start_stop, then 150 clk_100Hz rising edges → bcd_time 24'h000150, running 1.
- Stop/clear: after 1234 ticks, start_stop, then 10 more ticks → stays 24'h001234. clear → 24'h000000, state IDLE, running 0.
- Wrap: preload by running 359999 ticks → 24'h595999, overflow 0. One more tick → 24'h000000, overflow 1. Stop + clear → overflow 0.
- Lap (macro defined): lap at 24'h000042 with a simultaneous tick → bcd_time holds 24'h000042 while 100 ticks pass and lap_active is 1. lap again → 24'h000143.
- Lap (macro undefined): same stimulus → bcd_time 24'h000143 throughout, lap_active 0.
- Boundaries:
  - clk_100Hz high at reset release → no count.
  - clear+start_stop in RUN → STOP, count held.
  - rst mid-RUN → all outputs zero in one cycle.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch time-keeping core.
package stopwatch_pkg;

    localparam int unsigned BCD_W      = 4;
    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned DEC_MAX    = 9;
    localparam int unsigned SEX_MAX    = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2,
        LAP  = 2'd3
    } sw_state_t;

endpackage

// File: rtl/stopwatch_core_bcd_digit.sv
// One modulo-N BCD digit with count enable, synchronous clear and a
// combinational carry-out, so a chain of these ripples within one cycle.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int unsigned N = DEC_MAX + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [BCD_W-1:0] digit_o,
    output logic             carry_o
);

    localparam logic [BCD_W-1:0] LAST = BCD_W'(N - 1);

    logic [BCD_W-1:0] digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clr_i) begin
            digit_d = '0;
        end else if (en_i) begin
            digit_d = (digit_q == LAST) ? '0 : digit_q + BCD_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;
    assign carry_o = en_i & (digit_q == LAST);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch core: 100 Hz edge detect, MM:SS.cc BCD counter and run/stop/clear/lap FSM.
// Lap freeze (LAP state, lap register, display mux) exists only with STOPWATCH_LAP_EN.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX_MIN_TENS = 5
) (
    input  logic                          clk_50MHz,
    input  logic                          rst,
    input  logic                          clk_100Hz,
    input  logic                          btn_start_stop,
    input  logic                          btn_clear,
    input  logic                          btn_lap,
    output logic [NUM_DIGITS*BCD_W-1:0]   bcd_time,
    output logic                          running,
    output logic                          lap_active,
    output logic                          overflow
);

    sw_state_t                      state_q, state_d;
    logic                           clk_100hz_q;
    logic                           overflow_q, overflow_d;
    logic                           tick, cnt_en;
    logic                           clear_hit, lap_capture;
    logic [NUM_DIGITS*BCD_W-1:0]    count;
    logic [NUM_DIGITS:0]            carry;

    assign tick   = clk_100Hz & ~clk_100hz_q;
    assign cnt_en = tick & ((state_q == RUN) | (state_q == LAP));

    always_comb begin
        state_d     = state_q;
        clear_hit   = 1'b0;
        lap_capture = 1'b0;
        case (state_q)
            IDLE: if (btn_start_stop) state_d = RUN;
            RUN: begin
                if (btn_start_stop) begin
                    state_d = STOP;
`ifdef STOPWATCH_LAP_EN
                end else if (btn_lap) begin
                    state_d     = LAP;
                    lap_capture = 1'b1;
`endif
                end
            end
`ifdef STOPWATCH_LAP_EN
            LAP: begin
                if (btn_start_stop) state_d = STOP;
                else if (btn_lap)   state_d = RUN;
            end
`endif
            STOP: begin
                if (btn_clear) begin
                    state_d   = IDLE;
                    clear_hit = 1'b1;
                end else if (btn_start_stop) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        if (clear_hit)                  overflow_d = 1'b0;
        else if (carry[NUM_DIGITS])     overflow_d = 1'b1;
    end

    // Edge-detect history resets high so a source already high at release is not a tick.
    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            state_q     <= IDLE;
            clk_100hz_q <= 1'b1;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_100hz_q <= clk_100Hz;
            overflow_q  <= overflow_d;
        end
    end

    assign carry[0] = cnt_en;

    bcd_digit #(.N(DEC_MAX + 1)) u_c0 (.clk_i(clk_50MHz), .rst_i(rst), .clr_i(clear_hit),
        .en_i(carry[0]), .digit_o(count[3:0]),   .carry_o(carry[1]));
    bcd_digit #(.N(DEC_MAX + 1)) u_c1 (.clk_i(clk_50MHz), .rst_i(rst), .clr_i(clear_hit),
        .en_i(carry[1]), .digit_o(count[7:4]),   .carry_o(carry[2]));
    bcd_digit #(.N(DEC_MAX + 1)) u_s0 (.clk_i(clk_50MHz), .rst_i(rst), .clr_i(clear_hit),
        .en_i(carry[2]), .digit_o(count[11:8]),  .carry_o(carry[3]));
    bcd_digit #(.N(SEX_MAX + 1)) u_s1 (.clk_i(clk_50MHz), .rst_i(rst), .clr_i(clear_hit),
        .en_i(carry[3]), .digit_o(count[15:12]), .carry_o(carry[4]));
    bcd_digit #(.N(DEC_MAX + 1)) u_m0 (.clk_i(clk_50MHz), .rst_i(rst), .clr_i(clear_hit),
        .en_i(carry[4]), .digit_o(count[19:16]), .carry_o(carry[5]));
    bcd_digit #(.N(MAX_MIN_TENS + 1)) u_m1 (.clk_i(clk_50MHz), .rst_i(rst), .clr_i(clear_hit),
        .en_i(carry[5]), .digit_o(count[23:20]), .carry_o(carry[6]));

`ifdef STOPWATCH_LAP_EN
    logic [NUM_DIGITS*BCD_W-1:0] lap_q;

    // Captures the pre-edge count, so an increment at the lap edge is not shown.
    always_ff @(posedge clk_50MHz) begin
        if (rst)              lap_q <= '0;
        else if (lap_capture) lap_q <= count;
    end

    assign bcd_time   = (state_q == LAP) ? lap_q : count;
    assign lap_active = (state_q == LAP);
`else
    logic unused_lap;
    assign unused_lap = btn_lap ^ lap_capture;
    assign bcd_time   = count;
    assign lap_active = 1'b0;
`endif

    assign running  = (state_q == RUN) | (state_q == LAP);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: directed scenarios plus randomized buttons/clock against
// a centisecond-integer reference model.
module tb_stopwatch_core;

    localparam int MAXT = 5;
    localparam int MOD  = (MAXT + 1) * 60000;
    localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2, M_LAP = 3;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1, c100 = 1'b0, ss = 1'b0, clr = 1'b0, lap = 1'b0;
    logic [23:0] bcd_time;
    logic        running, lap_active, overflow;

    int n_vec = 0;
    int n_err = 0;

    int m_mode, m_count, m_lapv;
    bit m_ovf, m_prev;

    stopwatch_core #(.MAX_MIN_TENS(MAXT)) dut (
        .clk_50MHz(clk), .rst(rst), .clk_100Hz(c100),
        .btn_start_stop(ss), .btn_clear(clr), .btn_lap(lap),
        .bcd_time(bcd_time), .running(running), .lap_active(lap_active), .overflow(overflow)
    );

    always #10 clk = ~clk;

    function automatic logic [23:0] to_bcd(input int cs);
        int mins, secs, hs;
        mins = cs / 6000;
        secs = (cs / 100) % 60;
        hs   = cs % 100;
        return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10), 4'(hs / 10), 4'(hs % 10)};
    endfunction

    // Drives one cycle of inputs and advances the reference model across that edge.
    task automatic step(input bit r, input bit s, input bit c, input bit l, input bit f);
        bit tk;
        int old;
        @(negedge clk);
        rst = r; ss = s; clr = c; lap = l; c100 = f;
        @(posedge clk);
        if (r) begin
            m_mode = M_IDLE; m_count = 0; m_lapv = 0; m_ovf = 1'b0; m_prev = 1'b1;
        end else begin
            tk = f && !m_prev;
            m_prev = f;
            old = m_count;
            if (tk && (m_mode == M_RUN || m_mode == M_LAP)) begin
                m_count = m_count + 1;
                if (m_count == MOD) begin
                    m_count = 0;
                    m_ovf = 1'b1;
                end
            end
            case (m_mode)
                M_IDLE: if (s) m_mode = M_RUN;
                M_RUN: begin
                    if (s) m_mode = M_STOP;
                    else if (l && LAP_EN) begin m_mode = M_LAP; m_lapv = old; end
                end
                M_LAP: begin
                    if (s) m_mode = M_STOP;
                    else if (l) m_mode = M_RUN;
                end
                default: begin
                    if (c) begin m_mode = M_IDLE; m_count = 0; m_ovf = 1'b0; end
                    else if (s) m_mode = M_RUN;
                end
            endcase
        end
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 0, 0, 1);
            step(0, 0, 0, 0, 0);
        end
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (bcd_time !== 24'h000000) begin n_err++; $display("FAIL reset_bcd got %h want 000000", bcd_time); end
        n_vec++; if (running !== 1'b0) begin n_err++; $display("FAIL reset_running got %b want 0", running); end
        n_vec++; if (lap_active !== 1'b0) begin n_err++; $display("FAIL reset_lap got %b want 0", lap_active); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", overflow); end
    endtask

    task automatic test_start();
        do_reset();
        step(0, 1, 0, 0, 0);
        tick_n(150);
        n_vec++; if (bcd_time !== 24'h000150) begin n_err++; $display("FAIL start_bcd got %h want 000150", bcd_time); end
        n_vec++; if (running !== 1'b1) begin n_err++; $display("FAIL start_running got %b want 1", running); end
    endtask

    task automatic test_stop_clear();
        do_reset();
        step(0, 1, 0, 0, 0);
        tick_n(1234);
        n_vec++; if (bcd_time !== 24'h001234) begin n_err++; $display("FAIL run1234_bcd got %h want 001234", bcd_time); end
        step(0, 1, 0, 0, 0);
        tick_n(10);
        n_vec++; if (bcd_time !== 24'h001234) begin n_err++; $display("FAIL stop_hold_bcd got %h want 001234", bcd_time); end
        n_vec++; if (running !== 1'b0) begin n_err++; $display("FAIL stop_running got %b want 0", running); end
        step(0, 0, 1, 0, 0);
        n_vec++; if (bcd_time !== 24'h000000) begin n_err++; $display("FAIL clear_bcd got %h want 000000", bcd_time); end
        n_vec++; if (running !== 1'b0) begin n_err++; $display("FAIL clear_running got %b want 0", running); end
        // IDLE ignores clear-only and lap; start must resume from zero.
        step(0, 0, 0, 1, 0);
        n_vec++; if (running !== 1'b0) begin n_err++; $display("FAIL idle_lap_running got %b want 0", running); end
        step(0, 1, 0, 0, 0);
        tick_n(2);
        n_vec++; if (bcd_time !== 24'h000002) begin n_err++; $display("FAIL restart_bcd got %h want 000002", bcd_time); end
    endtask

    task automatic test_carry_chain();
        do_reset();
        step(0, 1, 0, 0, 0);
        tick_n(5999);
        n_vec++; if (bcd_time !== 24'h005999) begin n_err++; $display("FAIL chain_5999 got %h want 005999", bcd_time); end
        tick_n(1);
        n_vec++; if (bcd_time !== 24'h010000) begin n_err++; $display("FAIL chain_6000 got %h want 010000", bcd_time); end
    endtask

    task automatic test_wrap();
        do_reset();
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        force dut.u_m1.digit_q = 4'd5;
        force dut.u_m0.digit_q = 4'd9;
        force dut.u_s1.digit_q = 4'd5;
        force dut.u_s0.digit_q = 4'd9;
        force dut.u_c1.digit_q = 4'd9;
        force dut.u_c0.digit_q = 4'd0;
        step(0, 0, 0, 0, 0);
        release dut.u_m1.digit_q;
        release dut.u_m0.digit_q;
        release dut.u_s1.digit_q;
        release dut.u_s0.digit_q;
        release dut.u_c1.digit_q;
        release dut.u_c0.digit_q;
        m_count = MOD - 10;
        step(0, 0, 0, 0, 0);
        n_vec++; if (bcd_time !== 24'h595990) begin n_err++; $display("FAIL preload_bcd got %h want 595990", bcd_time); end
        step(0, 1, 0, 0, 0);
        tick_n(9);
        n_vec++; if (bcd_time !== 24'h595999) begin n_err++; $display("FAIL max_bcd got %h want 595999", bcd_time); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL max_ovf got %b want 0", overflow); end
        tick_n(1);
        n_vec++; if (bcd_time !== 24'h000000) begin n_err++; $display("FAIL wrap_bcd got %h want 000000", bcd_time); end
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL wrap_ovf got %b want 1", overflow); end
        tick_n(5);
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        n_vec++; if (bcd_time !== 24'h000005) begin n_err++; $display("FAIL after_wrap_bcd got %h want 000005", bcd_time); end
        step(0, 1, 0, 0, 0);
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL stop_ovf got %b want 1", overflow); end
        step(0, 0, 1, 0, 0);
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL clear_ovf got %b want 0", overflow); end
    endtask

    task automatic test_lap();
        logic [23:0] want_hold;
        logic        want_la;
        want_hold = LAP_EN ? 24'h000042 : 24'h000143;
        want_la   = LAP_EN;
        do_reset();
        step(0, 1, 0, 0, 0);
        tick_n(42);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0);
        tick_n(100);
        n_vec++; if (bcd_time !== want_hold) begin n_err++; $display("FAIL lap_hold_bcd got %h want %h", bcd_time, want_hold); end
        n_vec++; if (lap_active !== want_la) begin n_err++; $display("FAIL lap_active got %b want %b", lap_active, want_la); end
        n_vec++; if (running !== 1'b1) begin n_err++; $display("FAIL lap_running got %b want 1", running); end
        step(0, 0, 0, 1, 0);
        n_vec++; if (bcd_time !== 24'h000143) begin n_err++; $display("FAIL lap_release_bcd got %h want 000143", bcd_time); end
        n_vec++; if (lap_active !== 1'b0) begin n_err++; $display("FAIL lap_release_active got %b want 0", lap_active); end
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        n_vec++; if (running !== 1'b0) begin n_err++; $display("FAIL lap_to_stop_running got %b want 0", running); end
        n_vec++; if (bcd_time !== 24'h000143) begin n_err++; $display("FAIL lap_to_stop_bcd got %h want 000143", bcd_time); end
    endtask

    task automatic test_boundaries();
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        n_vec++; if (bcd_time !== 24'h000000) begin n_err++; $display("FAIL high_at_release got %h want 000000", bcd_time); end
        n_vec++; if (running !== 1'b1) begin n_err++; $display("FAIL high_at_release_run got %b want 1", running); end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        n_vec++; if (bcd_time !== 24'h000001) begin n_err++; $display("FAIL first_edge got %h want 000001", bcd_time); end
        tick_n(5);
        step(0, 1, 1, 0, 0);
        n_vec++; if (running !== 1'b0) begin n_err++; $display("FAIL clr_ss_run_running got %b want 0", running); end
        tick_n(3);
        n_vec++; if (bcd_time !== 24'h000006) begin n_err++; $display("FAIL clr_ss_run_bcd got %h want 000006", bcd_time); end
        step(0, 1, 0, 0, 0);
        tick_n(4);
        step(1, 0, 0, 0, 0);
        n_vec++; if (bcd_time !== 24'h000000) begin n_err++; $display("FAIL rst_mid_bcd got %h want 000000", bcd_time); end
        n_vec++; if (running !== 1'b0) begin n_err++; $display("FAIL rst_mid_running got %b want 0", running); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(0, 1, 0, 0, 0);
        tick_n(3);
        step(0, 1, 0, 0, 1);
        n_vec++; if (bcd_time !== 24'h000004) begin n_err++; $display("FAIL run_stop_tick got %h want 000004", bcd_time); end
        n_vec++; if (running !== 1'b0) begin n_err++; $display("FAIL run_stop_running got %b want 0", running); end
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1);
        n_vec++; if (bcd_time !== 24'h000004) begin n_err++; $display("FAIL stop_run_tick got %h want 000004", bcd_time); end
        n_vec++; if (running !== 1'b1) begin n_err++; $display("FAIL stop_run_running got %b want 1", running); end
        step(0, 0, 0, 0, 0);
        tick_n(1);
        n_vec++; if (bcd_time !== 24'h000005) begin n_err++; $display("FAIL resume_tick got %h want 000005", bcd_time); end
    endtask

    task automatic test_random();
        logic [23:0] e_bcd;
        bit r, s, c, l, f;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 399) == 0);
            s = ($urandom_range(0, 15) == 0);
            c = ($urandom_range(0, 11) == 0);
            l = ($urandom_range(0, 11) == 0);
            f = $urandom_range(0, 1) != 0;
            step(r, s, c, l, f);
            e_bcd = (LAP_EN && m_mode == M_LAP) ? to_bcd(m_lapv) : to_bcd(m_count);
            n_vec++; if (bcd_time !== e_bcd) begin n_err++; $display("FAIL rnd_bcd cyc %0d got %h want %h", i, bcd_time, e_bcd); end
            n_vec++; if (running !== (m_mode == M_RUN || m_mode == M_LAP)) begin
                n_err++; $display("FAIL rnd_running cyc %0d got %b mode %0d", i, running, m_mode); end
            n_vec++; if (lap_active !== (m_mode == M_LAP)) begin
                n_err++; $display("FAIL rnd_lap cyc %0d got %b mode %0d", i, lap_active, m_mode); end
            n_vec++; if (overflow !== m_ovf) begin n_err++; $display("FAIL rnd_ovf cyc %0d got %b want %b", i, overflow, m_ovf); end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_stop_clear();
        test_carry_chain();
        test_wrap();
        test_lap();
        test_boundaries();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
